// File: rtl/alto_task_scheduler_pkg.sv
// Shared widths, task numbers and payload types for the Alto microtask scheduler.
// Task numbering follows the Alto hardware assignment; higher number wins arbitration.
package alto_task_scheduler_pkg;

  localparam int unsigned NTASKS    = 16;
  localparam int unsigned TW        = 4;
  localparam int unsigned MPC_WIDTH = 10;

  typedef logic [TW-1:0]        task_t;
  typedef logic [MPC_WIDTH-1:0] mpc_t;
  typedef logic [NTASKS-1:0]    task_vec_t;

  localparam task_t ALTO_TASK_EMU         = TW'(0);
  localparam task_t ALTO_TASK_DISK_SECTOR = TW'(4);
  localparam task_t ALTO_TASK_ETHERNET    = TW'(7);
  localparam task_t ALTO_TASK_REFRESH     = TW'(8);
  localparam task_t ALTO_TASK_DISPLAY     = TW'(9);
  localparam task_t ALTO_TASK_CURSOR      = TW'(10);
  localparam task_t ALTO_TASK_DISK_WORD   = TW'(14);

  // Fields that move together on a task switch.
  typedef struct packed {
    task_t tsk;
    mpc_t  fetch;
    logic  switched;
  } sched_state_t;

  // One-hot mask selecting a single task's bit.
  function automatic task_vec_t task_onehot(input task_t t);
    return task_vec_t'(1) << t;
  endfunction

endpackage

// File: rtl/alto_task_priority.sv
// Fixed-priority arbiter: highest-numbered requesting task wins, task 0 always requests.
module alto_task_priority
  import alto_task_scheduler_pkg::*;
(
  input  logic [NTASKS-1:0] req_i,
  output logic [TW-1:0]     winner_o
);

  logic [NTASKS-1:0] req;

  always_comb begin
    req      = req_i | NTASKS'(1);
    winner_o = TW'(0);
    // Ascending scan so the last (highest) hit overrides lower ones.
    for (int unsigned i = 0; i < NTASKS; i++) begin
      if (req[i]) begin
        winner_o = TW'(i);
      end
    end
  end

endmodule

// File: rtl/alto_task_scheduler.sv
// Shares the microcode datapath among the 16 Alto microtasks: latches wakeups,
// arbitrates, and saves/restores per-task microprogram counters (TPC).
module alto_task_scheduler
  import alto_task_scheduler_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic [NTASKS-1:0]    wakeup_i,
  input  logic                 block_i,
  input  logic                 task_switch_i,
  input  logic [MPC_WIDTH-1:0] mpc_i,
  input  logic                 tpc_load_i,
  input  logic [TW-1:0]        tpc_task_i,
  input  logic [MPC_WIDTH-1:0] tpc_dat_i,
  output logic [TW-1:0]        task_o,
  output logic [TW-1:0]        next_task_o,
  output logic [MPC_WIDTH-1:0] fetch_addr_o,
  output logic [NTASKS-1:0]    pending_o,
  output logic                 switched_o
);

  sched_state_t st_q, st_d;
  task_vec_t    pending_q, pending_d;
  task_vec_t    req;
  task_t        next_task;
  mpc_t         tpc_q [NTASKS];
  mpc_t         tpc_d [NTASKS];
  logic         advance;

  assign advance = !stall_i;

  // BLOCK clears before arbitration; a same-cycle wakeup re-sets the bit.
  always_comb begin
    pending_d = pending_q;
    if (advance && block_i) begin
      pending_d = pending_d & ~task_onehot(st_q.tsk);
    end
    pending_d    = pending_d | wakeup_i;
    pending_d[0] = 1'b0;
    req          = pending_d;
  end

  alto_task_priority u_priority (
    .req_i    (req),
    .winner_o (next_task)
  );

  // Next-state: normal fetch, switch with TPC save/restore, and TPC loads.
  always_comb begin
    st_d          = st_q;
    st_d.switched = 1'b0;
    tpc_d         = tpc_q;
    if (advance) begin
      st_d.fetch = mpc_i;
      if (tpc_load_i) begin
        tpc_d[tpc_task_i] = tpc_dat_i;
      end
      if (task_switch_i) begin
        // Save is written after the load so it wins on an index collision.
        tpc_d[st_q.tsk] = mpc_i;
        st_d.tsk        = next_task;
        st_d.switched   = (next_task != st_q.tsk);
        if (next_task == st_q.tsk) begin
          st_d.fetch = mpc_i;
        end else if (tpc_load_i && (tpc_task_i == next_task)) begin
          st_d.fetch = tpc_dat_i;
        end else begin
          st_d.fetch = tpc_q[next_task];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < NTASKS; i++) begin
        tpc_q[i] <= MPC_WIDTH'(i);
      end
    end else begin
      st_q      <= st_d;
      pending_q <= pending_d;
      tpc_q     <= tpc_d;
    end
  end

  assign task_o       = st_q.tsk;
  assign fetch_addr_o = st_q.fetch;
  assign switched_o   = st_q.switched;
  assign pending_o    = pending_q | NTASKS'(1);
  assign next_task_o  = next_task;

endmodule

// File: tb/tb_alto_task_scheduler.sv
// Directed bench for alto_task_scheduler with hand-computed expectations.
module tb_alto_task_scheduler;
  import alto_task_scheduler_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b0;
  logic                 stall_i = 1'b0;
  logic [NTASKS-1:0]    wakeup_i = '0;
  logic                 block_i = 1'b0;
  logic                 task_switch_i = 1'b0;
  logic [MPC_WIDTH-1:0] mpc_i = '0;
  logic                 tpc_load_i = 1'b0;
  logic [TW-1:0]        tpc_task_i = '0;
  logic [MPC_WIDTH-1:0] tpc_dat_i = '0;
  logic [TW-1:0]        task_o;
  logic [TW-1:0]        next_task_o;
  logic [MPC_WIDTH-1:0] fetch_addr_o;
  logic [NTASKS-1:0]    pending_o;
  logic                 switched_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alto_task_scheduler dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .wakeup_i      (wakeup_i),
    .block_i       (block_i),
    .task_switch_i (task_switch_i),
    .mpc_i         (mpc_i),
    .tpc_load_i    (tpc_load_i),
    .tpc_task_i    (tpc_task_i),
    .tpc_dat_i     (tpc_dat_i),
    .task_o        (task_o),
    .next_task_o   (next_task_o),
    .fetch_addr_o  (fetch_addr_o),
    .pending_o     (pending_o),
    .switched_o    (switched_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, clear pulses, then let one rising edge pass.
  task automatic idle_inputs();
    stall_i = 1'b0; wakeup_i = '0; block_i = 1'b0; task_switch_i = 1'b0;
    tpc_load_i = 1'b0; tpc_task_i = '0; tpc_dat_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_i = 1'b1;
    #2;
    chk("rst_task",     32'(task_o),       32'h0);
    chk("rst_fetch",    32'(fetch_addr_o), 32'h0);
    chk("rst_pending",  32'(pending_o),    32'h0001);
    chk("rst_switched", 32'(switched_o),   32'h0);
    chk("rst_next",     32'(next_task_o),  32'h0);
    @(negedge clk_i); rst_i = 1'b0;

    // Switch with nothing pending: stays in task 0, TPC bypass.
    @(negedge clk_i); idle_inputs(); task_switch_i = 1'b1; mpc_i = 10'h123;
    tick();
    chk("t0_task",     32'(task_o),       32'h0);
    chk("t0_fetch",    32'(fetch_addr_o), 32'h123);
    chk("t0_switched", 32'(switched_o),   32'h0);
    chk("t0_tpc0",     32'(dut.tpc_q[0]), 32'h123);

    @(negedge clk_i); idle_inputs(); wakeup_i[ALTO_TASK_DISK_SECTOR] = 1'b1; mpc_i = 10'h011;
    tick();
    chk("wk4_fetch",   32'(fetch_addr_o), 32'h011);
    chk("wk4_pending", 32'(pending_o),    32'h0011);

    @(negedge clk_i); idle_inputs(); task_switch_i = 1'b1; mpc_i = 10'h050;
    chk("wk4_next",    32'(next_task_o),  32'h4);
    tick();
    chk("sw4_task",     32'(task_o),       32'h4);
    chk("sw4_fetch",    32'(fetch_addr_o), 32'h004);
    chk("sw4_switched", 32'(switched_o),   32'h1);
    chk("sw4_tpc0",     32'(dut.tpc_q[0]), 32'h050);

    @(negedge clk_i); idle_inputs(); wakeup_i[7] = 1'b1; wakeup_i[12] = 1'b1; mpc_i = 10'h090;
    tick();
    chk("norm_switched", 32'(switched_o),   32'h0);
    chk("norm_fetch",    32'(fetch_addr_o), 32'h090);
    chk("norm_pending",  32'(pending_o),    32'h1091);

    // BLOCK+TASK in task 4 with 7 and 12 pending.
    @(negedge clk_i); idle_inputs(); block_i = 1'b1; task_switch_i = 1'b1; mpc_i = 10'h0A0;
    tick();
    chk("blk_task",    32'(task_o),       32'hC);
    chk("blk_fetch",   32'(fetch_addr_o), 32'h00C);
    chk("blk_tpc4",    32'(dut.tpc_q[4]), 32'h0A0);
    chk("blk_pending", 32'(pending_o),    32'h1081);
    chk("blk_switched",32'(switched_o),   32'h1);

    @(negedge clk_i); idle_inputs(); block_i = 1'b1; task_switch_i = 1'b1; mpc_i = 10'h0C0;
    tick();
    chk("blk12_task",  32'(task_o),       32'h7);
    chk("blk12_fetch", 32'(fetch_addr_o), 32'h007);

    // Back to task 4: restores its saved TPC.
    @(negedge clk_i); idle_inputs(); block_i = 1'b1; task_switch_i = 1'b1; mpc_i = 10'h070;
    wakeup_i[4] = 1'b1;
    tick();
    chk("ret4_task",    32'(task_o),       32'h4);
    chk("ret4_fetch",   32'(fetch_addr_o), 32'h0A0);
    chk("ret4_pending", 32'(pending_o),    32'h0011);

    @(negedge clk_i); idle_inputs(); block_i = 1'b1; wakeup_i[4] = 1'b1; mpc_i = 10'h0A1;
    tick();
    chk("wkblk_pending", 32'(pending_o), 32'h0011);

    // Block+wakeup+TASK on self: reselected, bypass mpc, no switch pulse.
    @(negedge clk_i); idle_inputs(); block_i = 1'b1; wakeup_i[4] = 1'b1; task_switch_i = 1'b1;
    mpc_i = 10'h0A2;
    tick();
    chk("self_task",     32'(task_o),       32'h4);
    chk("self_fetch",    32'(fetch_addr_o), 32'h0A2);
    chk("self_switched", 32'(switched_o),   32'h0);
    chk("self_tpc4",     32'(dut.tpc_q[4]), 32'h0A2);

    @(negedge clk_i); idle_inputs(); block_i = 1'b1; mpc_i = 10'h0A3;
    tick();
    chk("clr4_pending", 32'(pending_o),   32'h0001);
    chk("clr4_next",    32'(next_task_o), 32'h0);

    // Stall freezes everything but wakeup latching.
    @(negedge clk_i); idle_inputs(); stall_i = 1'b1; task_switch_i = 1'b1; block_i = 1'b1;
    tpc_load_i = 1'b1; tpc_task_i = 4'd3; tpc_dat_i = 10'h155; wakeup_i[9] = 1'b1; mpc_i = 10'h1FF;
    tick();
    chk("stl_task",     32'(task_o),       32'h4);
    chk("stl_fetch",    32'(fetch_addr_o), 32'h0A3);
    chk("stl_tpc3",     32'(dut.tpc_q[3]), 32'h003);
    chk("stl_tpc4",     32'(dut.tpc_q[4]), 32'h0A2);
    chk("stl_pending",  32'(pending_o),    32'h0201);
    chk("stl_switched", 32'(switched_o),   32'h0);

    // Switch to 9 while loading tpc[9]: write-through.
    @(negedge clk_i); idle_inputs(); task_switch_i = 1'b1; tpc_load_i = 1'b1;
    tpc_task_i = 4'd9; tpc_dat_i = 10'h3FF; mpc_i = 10'h0B0;
    tick();
    chk("wt_task",     32'(task_o),       32'h9);
    chk("wt_fetch",    32'(fetch_addr_o), 32'h3FF);
    chk("wt_switched", 32'(switched_o),   32'h1);
    chk("wt_tpc9",     32'(dut.tpc_q[9]), 32'h3FF);
    chk("wt_tpc4",     32'(dut.tpc_q[4]), 32'h0B0);

    // Load collides with switch save on the current task: save wins.
    @(negedge clk_i); idle_inputs(); task_switch_i = 1'b1; tpc_load_i = 1'b1;
    tpc_task_i = 4'd9; tpc_dat_i = 10'h111; mpc_i = 10'h0C0;
    tick();
    chk("col_task",  32'(task_o),       32'h9);
    chk("col_fetch", 32'(fetch_addr_o), 32'h0C0);
    chk("col_tpc9",  32'(dut.tpc_q[9]), 32'h0C0);

    @(negedge clk_i); idle_inputs(); tpc_load_i = 1'b1; tpc_task_i = 4'd5; tpc_dat_i = 10'h255;
    mpc_i = 10'h0D0;
    tick();
    chk("ld5_tpc5",  32'(dut.tpc_q[5]), 32'h255);
    chk("ld5_fetch", 32'(fetch_addr_o), 32'h0D0);

    // Async reset in the middle of a switch cycle.
    @(negedge clk_i); idle_inputs(); block_i = 1'b1; task_switch_i = 1'b1; mpc_i = 10'h0E0;
    #2 rst_i = 1'b1;
    #1;
    chk("ar_task",     32'(task_o),       32'h0);
    chk("ar_fetch",    32'(fetch_addr_o), 32'h0);
    chk("ar_pending",  32'(pending_o),    32'h0001);
    chk("ar_switched", 32'(switched_o),   32'h0);
    chk("ar_tpc5",     32'(dut.tpc_q[5]), 32'h005);
    chk("ar_tpc9",     32'(dut.tpc_q[9]), 32'h009);
    tick();
    chk("ar_hold_task", 32'(task_o), 32'h0);
    @(negedge clk_i); idle_inputs(); rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
